// File: rtl/alu_ag_datapath.sv
// alu_ag_datapath: two-stage AG + integer ALU execute datapath.
// Stage 1 is an enable-gated operand/control register. Stage 2 registers
// the linear address, the ALU result and the flags every cycle.
// Optional feature macro: ALU_AG_FLAGS_EN. When it is defined, cf/af/of are
// computed and registered. When it is undefined, there are no flag flops
// and cf/af/of are tied to 0.
module alu_ag_datapath (
  input  logic        clk,
  input  logic        r,
  input  logic        e,
  input  logic        v_in,
  input  logic [31:0] dval,
  input  logic [31:0] sval,
  input  logic [31:0] disp,
  input  logic [15:0] sreg,
  input  logic [7:0]  modrm,
  input  logic        rmsel,
  input  logic [1:0]  alusel,
  output logic        v_out,
  output logic [31:0] addr,
  output logic [31:0] aluval,
  output logic        cf,
  output logic        af,
  output logic        of
);
  localparam int STAGES = 2;

  // vld_pipe[0] is the incoming valid; [1] and [2] are the stage registers
  logic [STAGES:0] vld_pipe;
  logic [31:0]     s1_dval, s1_sval, s1_disp;
  logic [15:0]     s1_sreg;
  logic [1:0]      s1_mod;
  logic            s1_rmsel;
  logic [1:0]      s1_alusel;

  logic [31:0]     base, ea, lin, res;

  // reg/rm fields never reach the datapath; only mod selects the AG form
  logic            unused_modrm;
  assign unused_modrm = ^modrm[5:0];

  assign vld_pipe[0] = v_in;

  // Stage 1: capture the µop when enabled, hold otherwise
  always_ff @(posedge clk) begin
    if (!r) begin
      vld_pipe[1] <= 1'b0;
      s1_dval     <= '0;
      s1_sval     <= '0;
      s1_disp     <= '0;
      s1_sreg     <= '0;
      s1_mod      <= '0;
      s1_rmsel    <= 1'b0;
      s1_alusel   <= '0;
    end else if (e) begin
      vld_pipe[1] <= vld_pipe[0];
      s1_dval     <= dval;
      s1_sval     <= sval;
      s1_disp     <= disp;
      s1_sreg     <= sreg;
      s1_mod      <= modrm[7:6];
      s1_rmsel    <= rmsel;
      s1_alusel   <= alusel;
    end
  end

  // AG: effective address by mod form, then add the segment base (all mod 2^32)
  always_comb begin
    base = s1_rmsel ? s1_sval : s1_dval;
    ea   = base;
    case (s1_mod)
      2'b01:   ea = base + {{24{s1_disp[7]}}, s1_disp[7:0]};
      2'b10:   ea = base + s1_disp;
      default: ea = base;
    endcase
    lin = ea + {12'h000, s1_sreg, 4'h0};
  end

`ifdef ALU_AG_FLAGS_EN
  logic [32:0] sum33, dif33;
  logic        cf_n, af_n, of_n;

  // ALU with flags: 33-bit add/sub gives the carry/borrow out of bit 31, and
  // a[4]^b[4]^r[4] gives the carry/borrow across the bit 3/4 boundary
  always_comb begin
    sum33 = {1'b0, s1_dval} + {1'b0, s1_sval};
    dif33 = {1'b0, s1_dval} - {1'b0, s1_sval};
    res   = '0;
    cf_n  = 1'b0;
    af_n  = 1'b0;
    of_n  = 1'b0;
    case (s1_alusel)
      2'b00: begin
        res  = sum33[31:0];
        cf_n = sum33[32];
        af_n = s1_dval[4] ^ s1_sval[4] ^ sum33[4];
        of_n = (s1_dval[31] == s1_sval[31]) && (sum33[31] != s1_dval[31]);
      end
      2'b01: begin
        res  = dif33[31:0];
        cf_n = dif33[32];
        af_n = s1_dval[4] ^ s1_sval[4] ^ dif33[4];
        of_n = (s1_dval[31] != s1_sval[31]) && (dif33[31] != s1_dval[31]);
      end
      2'b10:   res = s1_dval & s1_sval;
      default: res = s1_sval;
    endcase
  end

  // Stage 2 flags: registered every cycle
  always_ff @(posedge clk) begin
    if (!r) begin
      cf <= 1'b0;
      af <= 1'b0;
      of <= 1'b0;
    end else begin
      cf <= cf_n;
      af <= af_n;
      of <= of_n;
    end
  end
`else
  // ALU without flags: result only
  always_comb begin
    res = '0;
    case (s1_alusel)
      2'b00:   res = s1_dval + s1_sval;
      2'b01:   res = s1_dval - s1_sval;
      2'b10:   res = s1_dval & s1_sval;
      default: res = s1_sval;
    endcase
  end

  assign cf = 1'b0;
  assign af = 1'b0;
  assign of = 1'b0;
`endif

  // Stage 2: address, result and valid load unconditionally every cycle
  always_ff @(posedge clk) begin
    if (!r) begin
      vld_pipe[2] <= 1'b0;
      addr        <= '0;
      aluval      <= '0;
    end else begin
      vld_pipe[2] <= vld_pipe[1];
      addr        <= lin;
      aluval      <= res;
    end
  end

  assign v_out = vld_pipe[STAGES];
endmodule

// File: tb/tb_alu_ag_datapath.sv
// tb_alu_ag_datapath: table-driven directed vectors plus hand-written
// sequences for hold, back-to-back, v_in=0 and mid-flight reset.
module tb_alu_ag_datapath;
  logic        clk = 1'b0;
  logic        r, e, v_in, rmsel;
  logic [31:0] dval, sval, disp;
  logic [15:0] sreg;
  logic [7:0]  modrm;
  logic [1:0]  alusel;
  logic        v_out, cf, af, of;
  logic [31:0] addr, aluval;

`ifdef ALU_AG_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  alu_ag_datapath dut (
    .clk(clk), .r(r), .e(e), .v_in(v_in), .dval(dval), .sval(sval),
    .disp(disp), .sreg(sreg), .modrm(modrm), .rmsel(rmsel), .alusel(alusel),
    .v_out(v_out), .addr(addr), .aluval(aluval), .cf(cf), .af(af), .of(of)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dval, sval, disp;
    logic [15:0] sreg;
    logic [7:0]  modrm;
    logic        rmsel;
    logic [1:0]  alusel;
    logic [31:0] x_addr, x_alu;
    logic        x_cf, x_af, x_of;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic xv, input logic [31:0] xa,
                         input logic [31:0] xr, input logic xc, input logic xf,
                         input logic xo);
    chk({tag, ".v_out"},  {31'b0, v_out}, {31'b0, xv});
    chk({tag, ".addr"},   addr, xa);
    chk({tag, ".aluval"}, aluval, xr);
    chk({tag, ".cf"},     {31'b0, cf}, {31'b0, xc & FL});
    chk({tag, ".af"},     {31'b0, af}, {31'b0, xf & FL});
    chk({tag, ".of"},     {31'b0, of}, {31'b0, xo & FL});
  endtask

  task automatic drive(input vec_t v);
    dval = v.dval; sval = v.sval; disp = v.disp; sreg = v.sreg;
    modrm = v.modrm; rmsel = v.rmsel; alusel = v.alusel;
  endtask

  initial begin
    //        dval          sval          disp          sreg      modrm  rs  op     addr          alu           c  a  o
    vt[0]  = '{32'h2,        32'hABCD,     32'h2,        16'h0DEF, 8'h91, 0, 2'b11, 32'h0000DEF4, 32'h0000ABCD, 0, 0, 0};
    vt[1]  = '{32'hFFFFFFFF, 32'h1,        32'h0,        16'h0,    8'h00, 0, 2'b00, 32'hFFFFFFFF, 32'h0,        1, 1, 0};
    vt[2]  = '{32'h7FFFFFFF, 32'h1,        32'h0,        16'h0,    8'h00, 0, 2'b00, 32'h7FFFFFFF, 32'h80000000, 0, 1, 1};
    vt[3]  = '{32'h0,        32'h1,        32'h0,        16'h0,    8'h00, 0, 2'b01, 32'h0,        32'hFFFFFFFF, 1, 1, 0};
    vt[4]  = '{32'h100,      32'h0,        32'hF0,       16'h0,    8'h40, 0, 2'b11, 32'hF0,       32'h0,        0, 0, 0};
    vt[5]  = '{32'h100,      32'h0,        32'hF0,       16'h0,    8'h00, 0, 2'b11, 32'h100,      32'h0,        0, 0, 0};
    vt[6]  = '{32'h100,      32'h0,        32'h1234,     16'h0,    8'hC7, 0, 2'b11, 32'h100,      32'h0,        0, 0, 0};
    vt[7]  = '{32'h100,      32'h200,      32'h0,        16'h0,    8'h00, 1, 2'b00, 32'h200,      32'h300,      0, 0, 0};
    vt[8]  = '{32'hF0F0,     32'h0FF0,     32'h0,        16'h0,    8'h00, 0, 2'b10, 32'hF0F0,     32'h00F0,     0, 0, 0};
    vt[9]  = '{32'h80000000, 32'h1,        32'hFFFFFFFF, 16'h1,    8'h80, 0, 2'b01, 32'h8000000F, 32'h7FFFFFFF, 0, 1, 1};
    vt[10] = '{32'hFFFFFFF0, 32'h10,       32'h20,       16'hFFFF, 8'hBF, 0, 2'b01, 32'h00100000, 32'hFFFFFFE0, 0, 0, 0};

    r = 1'b0; e = 1'b1; v_in = 1'b1;
    drive(vt[0]);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all("reset", 0, 0, 0, 0, 0, 0);
    r = 1'b1; e = 1'b0;

    // table: load once with e=1, then e=0; outputs valid after the 2nd edge
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(vt[i]); e = 1'b1; v_in = 1'b1;
      @(negedge clk);
      e = 1'b0;
      drive(vt[(i + 5) % 11]);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), 1, vt[i].x_addr, vt[i].x_alu,
              vt[i].x_cf, vt[i].x_af, vt[i].x_of);
    end

    // hold: e=0 keeps outputs constant with other inputs changing
    repeat (3) @(negedge clk);
    chk_all("hold", 1, vt[10].x_addr, vt[10].x_alu, vt[10].x_cf, vt[10].x_af, vt[10].x_of);

    // back-to-back: one µop per cycle
    drive(vt[1]); e = 1'b1; v_in = 1'b1;
    @(negedge clk);
    drive(vt[2]); v_in = 1'b0;
    @(negedge clk);
    e = 1'b0;
    chk_all("b2b0", 1, vt[1].x_addr, vt[1].x_alu, vt[1].x_cf, vt[1].x_af, vt[1].x_of);
    @(negedge clk);
    chk_all("b2b1_vin0", 0, vt[2].x_addr, vt[2].x_alu, vt[2].x_cf, vt[2].x_af, vt[2].x_of);

    // reset while a µop is in flight in stage 1 and 2
    drive(vt[0]); e = 1'b1; v_in = 1'b1;
    @(negedge clk);
    e = 1'b0;
    @(negedge clk);
    r = 1'b0;
    @(negedge clk);
    chk_all("rst_mid", 0, 0, 0, 0, 0, 0);
    r = 1'b1;
    repeat (2) @(negedge clk);
    chk_all("rst_after", 0, 0, 0, 0, 0, 0);

    // reset overrides e
    drive(vt[3]); e = 1'b1; r = 1'b0;
    @(negedge clk);
    r = 1'b1; e = 1'b0;
    repeat (2) @(negedge clk);
    chk_all("rst_over_e", 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
